edge_irq_arbiter: RTL and testbench

Multi-channel edge-triggered interrupt controller that sits between asynchronous interrupt lines and a single service agent. Each channel synchronizes its input, detects the edge type selected for that channel, and latches a pending request with overflow flagging. A round-robin arbiter presents one pending channel at a time over a valid/ack handshake.

---
 rtl/edge_irq_arbiter.sv | 148 ++++++++++++++
 tb/tb_edge_irq_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_irq_arbiter.sv
// Edge-triggered interrupt controller: per-channel synchronizer and edge detect,
// sticky pending/overflow latches, and a round-robin valid/ack presenter.
module edge_irq_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     rx_int,
    input  logic [2*N-1:0]   mode,
    input  logic             irq_ack,
    input  logic [N-1:0]     ovf_clr,
    output logic             irq_valid,
    output logic [IDW-1:0]   irq_id,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     ovf
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    logic [N-1:0]   s1_q, s2_q, s3_q;
    logic [1:0]     warm_q, warm_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   ovf_q, ovf_d;
    state_t         state_q, state_d;
    logic           valid_q, valid_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] last_q, last_d;

    logic [N-1:0]   enabled, edge_det, ready;
    logic           ack_fire;
    logic           found;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] cand;
    logic           granted_i;

    assign ack_fire = valid_q & irq_ack;
    assign ready    = pending_q & enabled;

    // Edges are suppressed until the warm-up counter saturates, so a line
    // already high at reset release does not look like a rising edge.
    always_comb begin
        enabled  = '0;
        edge_det = '0;
        for (int i = 0; i < N; i++) begin
            enabled[i]  = |mode[2*i +: 2];
            edge_det[i] = (warm_q == 2'd3) &&
                          ((mode[2*i]   && s2_q[i] && !s3_q[i]) ||
                           (mode[2*i+1] && !s2_q[i] && s3_q[i]));
        end
    end

    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q & ~ovf_clr;
        granted_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            granted_i = valid_q && (id_q == IDW'(i));
            if (ack_fire && granted_i)
                pending_d[i] = edge_det[i];
            else if (!enabled[i] && !granted_i)
                pending_d[i] = 1'b0;
            else
                pending_d[i] = pending_q[i] | edge_det[i];
            if (edge_det[i] && pending_q[i] && !(ack_fire && granted_i))
                ovf_d[i] = 1'b1;
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(last_q) + 1 + k) % N);
            if (!found && ready[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        warm_d  = (warm_q == 2'd3) ? 2'd3 : warm_q + 2'd1;
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    valid_d = 1'b1;
                    id_d    = sel;
                    last_d  = sel;
                end
            end
            GRANT: begin
                if (irq_ack) begin
                    state_d = GAP;
                    valid_d = 1'b0;
                    id_d    = '0;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                id_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            warm_q    <= 2'd0;
            pending_q <= '0;
            ovf_q     <= '0;
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            id_q      <= '0;
            last_q    <= IDW'(N - 1);
        end else begin
            s1_q      <= rx_int;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            warm_q    <= warm_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            last_q    <= last_d;
        end
    end

    assign irq_valid = valid_q;
    assign irq_id    = id_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_irq_arbiter.sv
// Directed bench for edge_irq_arbiter: expected grant ids queued at stimulus
// time and popped when the DUT presents a request.
module tb_edge_irq_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   rx_int;
    logic [2*N-1:0] mode;
    logic           irq_ack;
    logic [N-1:0]   ovf_clr;
    logic           irq_valid;
    logic [IDW-1:0] irq_id;
    logic [N-1:0]   pending;
    logic [N-1:0]   ovf;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    edge_irq_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_int    (rx_int),
        .mode      (mode),
        .irq_ack   (irq_ack),
        .ovf_clr   (ovf_clr),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input string tag, output int cyc);
        int exp_id;
        cyc = 0;
        while (irq_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_valid"}, {31'd0, irq_valid}, 32'd1);
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk({tag, "_id"}, {30'd0, irq_id}, exp_id);
    endtask

    task automatic ack_now(input string tag);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk({tag, "_drop"}, {31'd0, irq_valid}, 32'd0);
    endtask

    task automatic quiet(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (irq_valid !== 1'b0) seen++;
        end
        chk(tag, seen, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(4);
    endtask

    initial begin
        int cyc;
        int viol;
        rst = 1'b1; rx_int = '0; mode = '0; irq_ack = 1'b0; ovf_clr = '0;
        ticks(2);
        chk("rst_valid", {31'd0, irq_valid}, 32'd0);
        chk("rst_id", {30'd0, irq_id}, 32'd0);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        chk("rst_ovf", {28'd0, ovf}, 32'd0);
        rst = 1'b0;
        ticks(4);

        // Single rising edge on channel 0: 4-cycle latency, ack at E6
        mode = 8'h01;
        rx_int[0] = 1'b1;
        exp_q.push_back(0);
        ticks(3);
        chk("lat_pend_e3", {28'd0, pending}, 32'h1);
        chk("lat_novalid_e3", {31'd0, irq_valid}, 32'd0);
        wait_grant("single", cyc);
        chk("single_latency", cyc, 1);
        tick();
        chk("single_hold", {31'd0, irq_valid}, 32'd1);
        ack_now("single");
        chk("single_pend_clr", {28'd0, pending}, 32'd0);
        quiet("single_no_second", 10);
        mode = 8'h00;
        rx_int = '0;
        ticks(4);

        // Both-edges on channel 2: a 10-cycle pulse yields two grants
        mode = 8'h30;
        exp_q.push_back(2);
        exp_q.push_back(2);
        rx_int[2] = 1'b1;
        wait_grant("both_rise", cyc);
        ack_now("both_rise");
        ticks(9 - cyc);
        rx_int[2] = 1'b0;
        wait_grant("both_fall", cyc);
        ack_now("both_fall");
        quiet("both_no_third", 12);
        chk("both_ovf", {28'd0, ovf}, 32'd0);

        // Round-robin from reset, then wrap after last_id=3
        mode = 8'h55;
        do_reset();
        rx_int = 4'hF;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < N; c++) exp_q.push_back(c);
            for (int c = 0; c < N; c++) begin
                wait_grant("rr", cyc);
                ack_now("rr");
            end
            rx_int = 4'h0;
            ticks(4);
            rx_int = 4'hF;
        end
        ticks(6);
        exp_q.push_back(0);
        for (int c = 1; c < N; c++) exp_q.push_back(c);
        for (int c = 0; c < N; c++) begin
            wait_grant("rr_extra", cyc);
            ack_now("rr_extra");
        end
        chk("rr_ovf", {28'd0, ovf}, 32'd0);

        // Overflow on channel 1, clear, then edge coinciding with ack
        mode = 8'h04;
        rx_int = 4'h0;
        ticks(4);
        exp_q.push_back(1);
        rx_int[1] = 1'b1;
        wait_grant("ovf_first", cyc);
        rx_int[1] = 1'b0;
        ticks(2);
        rx_int[1] = 1'b1;
        ticks(3);
        chk("ovf_set", {28'd0, ovf}, 32'h2);
        chk("ovf_pend", {28'd0, pending}, 32'h2);
        chk("ovf_still_valid", {31'd0, irq_valid}, 32'd1);
        ovf_clr = 4'h2;
        tick();
        ovf_clr = 4'h0;
        chk("ovf_cleared", {28'd0, ovf}, 32'd0);
        rx_int[1] = 1'b0;
        ticks(3);
        rx_int[1] = 1'b1;
        ticks(2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("coll_pend", {28'd0, pending}, 32'h2);
        chk("coll_ovf", {28'd0, ovf}, 32'd0);
        chk("coll_drop", {31'd0, irq_valid}, 32'd0);
        exp_q.push_back(1);
        wait_grant("coll_regrant", cyc);
        ack_now("coll_regrant");

        // Reset release with all lines high, then reset mid-grant
        rx_int = 4'hF;
        mode = 8'h55;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pending !== 4'h0 || irq_valid !== 1'b0) viol++;
        end
        chk("warmup_quiet", viol, 0);
        rx_int = 4'h0;
        ticks(3);
        rx_int = 4'h1;
        exp_q.push_back(0);
        wait_grant("pre_rst", cyc);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, irq_valid}, 32'd0);
        chk("midrst_pending", {28'd0, pending}, 32'd0);
        chk("midrst_id", {30'd0, irq_id}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ticks(4);

        // Disable channel 3 while it waits behind channel 0
        rx_int = 4'h0;
        ticks(4);
        rx_int = 4'b1001;
        exp_q.push_back(0);
        wait_grant("dis", cyc);
        chk("dis_both_pend", {28'd0, pending}, 32'h9);
        mode = 8'h15;
        tick();
        chk("dis_pend3_clr", {28'd0, pending}, 32'h1);
        ack_now("dis");
        quiet("dis_never_granted", 10);

        chk("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
